// File: rtl/intc_pkg.sv
// Shared constants for the interrupt controller: register map, FSM states, default source count.
package intc_pkg;
  localparam int NSRC_DEF = 6;
  localparam int ID_W     = 3;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_VEC  = 2'd2;
  localparam logic [1:0] ADDR_MODE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;
endpackage

// File: rtl/intc_prio_enc.sv
// Winner selection: first set request found when scanning upward from start, wrapping at NSRC.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int NSRC = NSRC_DEF
) (
  input  logic [NSRC-1:0] req,
  input  logic [ID_W-1:0] start,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  int idx;

  // Scan from the far end so the candidate closest to start is written last and wins.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NSRC) idx = idx - NSRC;
      if (req[idx]) begin
        id    = ID_W'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// MIPS-style interrupt controller: MASK/PEND/VEC/MODE registers and an IDLE/ASSERT/SERVICE handshake.
// Define INTC_ROTATE_PRIORITY_EN for round-robin priority; default build uses fixed lowest-index priority.
module int_ctrl
  import intc_pkg::*;
#(
  parameter int NSRC = NSRC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_i,
  input  logic [3:2]      ADD_I,
  input  logic            WE_I,
  input  logic            RE_I,
  input  logic [31:0]     DAT_I,
  output logic [31:0]     DAT_O,
  output logic            IRQ_O
);

  logic [NSRC-1:0] mask, mode, pend, irq_q, irq_d;
  logic [NSRC-1:0] rise, pend_clr, eoi_clr;
  logic [ID_W-1:0] id_q, win_id, start;
  logic            win_vld, irq_o_q;
  logic            wr_mask, wr_pend, wr_mode, eoi, vec_rd;
  state_t          state, state_nxt;
  logic            unused_dat;

  assign unused_dat = ^DAT_I[31:NSRC];

  assign wr_mask = WE_I && (ADD_I == ADDR_MASK);
  assign wr_pend = WE_I && (ADD_I == ADDR_PEND);
  assign wr_mode = WE_I && (ADD_I == ADDR_MODE);
  assign eoi     = WE_I && (ADD_I == ADDR_VEC) && (state == ST_SERVICE);
  assign vec_rd  = RE_I && (ADD_I == ADDR_VEC);

  assign rise     = irq_q & ~irq_d;
  assign eoi_clr  = eoi ? (NSRC'(1) << id_q) : '0;
  assign pend_clr = (wr_pend ? DAT_I[NSRC-1:0] : '0) | eoi_clr;

`ifdef INTC_ROTATE_PRIORITY_EN
  logic [ID_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (reset)    rr_ptr <= '0;
    else if (eoi) rr_ptr <= (id_q == ID_W'(NSRC - 1)) ? '0 : id_q + 1'b1;
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  intc_prio_enc #(.NSRC(NSRC)) u_prio (
    .req   (pend & mask),
    .start (start),
    .id    (win_id),
    .valid (win_vld)
  );

  // Input sync, edge detect history, and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= '0;
      irq_d <= '0;
      mask  <= '0;
      mode  <= '0;
      pend  <= '0;
    end else begin
      irq_q <= irq_i;
      irq_d <= irq_q;
      if (wr_mask) mask <= DAT_I[NSRC-1:0];
      if (wr_mode) mode <= DAT_I[NSRC-1:0];
      // A new edge wins over a same-cycle clear; level sources simply mirror irq_q.
      pend <= (mode & ((pend & ~pend_clr) | rise)) | (~mode & irq_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      id_q    <= '0;
      irq_o_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      irq_o_q <= (state_nxt == ST_ASSERT);
      if (state == ST_IDLE && win_vld) id_q <= win_id;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (win_vld) state_nxt = ST_ASSERT;
      ST_ASSERT: begin
        if (!(pend[id_q] && mask[id_q])) state_nxt = ST_IDLE;
        else if (vec_rd)                 state_nxt = ST_SERVICE;
      end
      ST_SERVICE: if (eoi) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    DAT_O = '0;
    case (ADD_I)
      ADDR_MASK: DAT_O[NSRC-1:0] = mask;
      ADDR_PEND: DAT_O[NSRC-1:0] = pend;
      ADDR_VEC: begin
        if (state != ST_IDLE) begin
          DAT_O[31]       = 1'b1;
          DAT_O[ID_W-1:0] = id_q;
        end
      end
      ADDR_MODE: DAT_O[NSRC-1:0] = mode;
      default:   DAT_O = '0;
    endcase
  end

  assign IRQ_O = irq_o_q;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 6, number of interrupt sources, one per MIPS HWInt[7:2] line.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port irq_i, input, NSRC, raw device request lines, such as timer IRQ, bit 0 = source 0.
REQ-005 SHALL have port ADD_I, input, [3:2], register word select from bridge.
REQ-006 SHALL have port WE_I, input, 1, write strobe for one cycle per store.
REQ-007 SHALL have port RE_I, input, 1, read strobe for one cycle per load; used only for read side effects.
REQ-008 SHALL have port DAT_I, input, 32, write data.
REQ-009 SHALL have port DAT_O, output, 32, combinational read data of the selected register.
REQ-010 SHALL have port IRQ_O, output, 1, merged interrupt request to CPU.

Function
REQ-011 SHALL implement registers: 0 MASK (RW, bit i=1 enables source i); 1 PEND (read: pending bits; write: 1 clears that edge-mode pending bit); 2 VEC (read = {valid bit 31, id in [2:0]} of in-service source; write = end-of-interrupt, EOI); 3 MODE (RW, bit i=1 edge, 0 level). Unused bits read 0.
REQ-012 SHALL register irq_i once (irq_q); edge-mode pending bit set on irq_q rising edge; level-mode pending bit = irq_q each cycle.
REQ-013 SHALL give set priority over a simultaneous write-1-to-clear of the same PEND bit.
REQ-014 SHALL run FSM IDLE -> ASSERT -> SERVICE -> IDLE.
REQ-015 In IDLE, when (PEND & MASK) != 0, SHALL latch the winner id and enter ASSERT the next cycle.
REQ-016 In ASSERT, IRQ_O SHALL be 1; RE_I with ADD_I=2 SHALL move to SERVICE the next cycle.
REQ-017 In SERVICE, IRQ_O SHALL be 0 and further requests are held pending, with no nesting.
REQ-018 A VEC write (EOI) in SERVICE SHALL clear the in-service edge-mode pending bit and return to IDLE the next cycle.
REQ-019 SHALL ignore an EOI in IDLE or ASSERT.
REQ-020 If the winner's MASK bit clears during ASSERT, SHALL return to IDLE with IRQ_O deasserting the next cycle.
REQ-021 SHALL have IRQ_O registered; latency from irq_i rising to IRQ_O=1 is 3 cycles (sync, pend, ASSERT).
REQ-022 With fixed priority, the lowest index SHALL win.

Reset
REQ-023 On reset SHALL clear MASK=0, PEND=0, MODE=0, irq_q=0 and in-service id=0, set state to IDLE and drive IRQ_O=0; reset mid-service SHALL discard the in-service state without EOI.

Configuration
REQ-024 With INTC_ROTATE_PRIORITY_EN defined, priority SHALL be round-robin: search starts at (last serviced id + 1) mod NSRC; the pointer updates on EOI and resets to 0.
REQ-025 Without INTC_ROTATE_PRIORITY_EN, priority SHALL be fixed per REQ-022 and no pointer register exists.

Structure
REQ-026 SHALL place register address constants, state enum and default NSRC in shared package intc_pkg.
REQ-027 SHALL implement winner selection in sub-module intc_prio_enc (inputs: request vector, start pointer; outputs: id, valid).

Verification
REQ-028 MASK=0x3F, MODE=0x3F, pulse irq_i[1] -> IRQ_O=1 after 3 cycles; VEC read=0x80000001; EOI -> PEND=0, IRQ_O stays 0.
REQ-029 irq_i[4] and irq_i[2] rise together, fixed mode -> VEC read=0x80000002 first; after EOI, the next VEC read=0x80000004.
REQ-030 Level source 0 (MODE=0) held high through EOI -> re-enters ASSERT, IRQ_O=1 again within 2 cycles; dropping irq_i[0] before the VEC read returns to IDLE.
REQ-031 MASK=0x00, pulse irq_i[3] -> PEND=0x08, IRQ_O=0; write MASK=0x08 -> IRQ_O=1 2 cycles later.
REQ-032 Assert reset during SERVICE -> all registers 0, IRQ_O=0, VEC read=0x00000000.
REQ-033 INTC_ROTATE_PRIORITY_EN, sources 0 and 1 held high (level) -> service order 0,1,0,1.
